// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: operand select, ALU, branch compare and the EX/MEM register (falling-edge capture).
// Define EX_FWD_EN to compile in EX/MEM and MEM/WB operand forwarding; the forwarding ports exist in both builds.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_data_1_IDEX,
  input  logic [31:0] read_data_2_IDEX,
  input  logic [31:0] immgen_IDEX,
  input  logic [31:0] pc_IDEX,
  input  logic [3:0]  Alu_sel_IDEX,
  input  logic        Asel_IDEX,
  input  logic        Bsel_IDEX,
  input  logic        BrUn_IDEX,
  input  logic        MemRW_IDEX,
  input  logic        regWen_IDEX,
  input  logic [1:0]  WBsel_IDEX,
  input  logic [4:0]  rd_IDEX,
  input  logic [4:0]  rs1_IDEX,
  input  logic [4:0]  rs2_IDEX,
  input  logic [31:0] wb_data_MEMWB,
  input  logic [4:0]  rd_MEMWB,
  input  logic        regWen_MEMWB,
  input  logic        flush_EX,
  output logic        BrEq,
  output logic        BrLt,
  output logic [31:0] alu_EXMEM,
  output logic [31:0] store_data_EXMEM,
  output logic [31:0] pc_plus4_EXMEM,
  output logic [4:0]  rd_EXMEM,
  output logic [1:0]  WBsel_EXMEM,
  output logic        MemRW_EXMEM,
  output logic        regWen_EXMEM
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [4:0]  shamt;

`ifdef EX_FWD_EN
  logic        exmem_fwd_ok;
  logic        memwb_fwd_ok;
  logic [31:0] exmem_val;

  // Loads sitting in EX/MEM are never forwarded; upstream stalls for load-use.
  always_comb begin
    exmem_fwd_ok = regWen_EXMEM && (rd_EXMEM != 5'd0) &&
                   ((WBsel_EXMEM == 2'b01) || (WBsel_EXMEM == 2'b10));
    memwb_fwd_ok = regWen_MEMWB && (rd_MEMWB != 5'd0);
    exmem_val    = (WBsel_EXMEM == 2'b10) ? pc_plus4_EXMEM : alu_EXMEM;
    fwd_a        = read_data_1_IDEX;
    fwd_b        = read_data_2_IDEX;
    if (exmem_fwd_ok && (rd_EXMEM == rs1_IDEX))
      fwd_a = exmem_val;
    else if (memwb_fwd_ok && (rd_MEMWB == rs1_IDEX))
      fwd_a = wb_data_MEMWB;
    if (exmem_fwd_ok && (rd_EXMEM == rs2_IDEX))
      fwd_b = exmem_val;
    else if (memwb_fwd_ok && (rd_MEMWB == rs2_IDEX))
      fwd_b = wb_data_MEMWB;
  end
`else
  logic unused_fwd_inputs;

  assign fwd_a = read_data_1_IDEX;
  assign fwd_b = read_data_2_IDEX;
  assign unused_fwd_inputs = ^{rs1_IDEX, rs2_IDEX, wb_data_MEMWB, rd_MEMWB, regWen_MEMWB};
`endif

  assign op_a  = Asel_IDEX ? pc_IDEX : fwd_a;
  assign op_b  = Bsel_IDEX ? immgen_IDEX : fwd_b;
  assign shamt = op_b[4:0];

  // Branch compare always looks at the register operands, never at pc/imm.
  assign BrEq = (fwd_a == fwd_b);
  assign BrLt = BrUn_IDEX ? (fwd_a < fwd_b) : ($signed(fwd_a) < $signed(fwd_b));

  always_comb begin
    alu_result = 32'd0;
    case (Alu_sel_IDEX)
      4'd0:    alu_result = op_a + op_b;
      4'd1:    alu_result = op_a - op_b;
      4'd2:    alu_result = op_a << shamt;
      4'd3:    alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd4:    alu_result = {31'd0, op_a < op_b};
      4'd5:    alu_result = op_a ^ op_b;
      4'd6:    alu_result = op_a >> shamt;
      4'd7:    alu_result = $signed(op_a) >>> shamt;
      4'd8:    alu_result = op_a | op_b;
      4'd9:    alu_result = op_a & op_b;
      4'd10:   alu_result = op_b;
      default: alu_result = 32'd0;
    endcase
  end

  // A flushed instruction keeps its data but loses every side effect, leaving an ALU-writeback bubble.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_EXMEM        <= 32'd0;
      store_data_EXMEM <= 32'd0;
      pc_plus4_EXMEM   <= 32'd0;
      rd_EXMEM         <= 5'd0;
      WBsel_EXMEM      <= 2'b00;
      MemRW_EXMEM      <= 1'b0;
      regWen_EXMEM     <= 1'b0;
    end else begin
      alu_EXMEM        <= alu_result;
      store_data_EXMEM <= fwd_b;
      pc_plus4_EXMEM   <= pc_IDEX + 32'd4;
      if (flush_EX) begin
        rd_EXMEM     <= 5'd0;
        WBsel_EXMEM  <= 2'b01;
        MemRW_EXMEM  <= 1'b0;
        regWen_EXMEM <= 1'b0;
      end else begin
        rd_EXMEM     <= rd_IDEX;
        WBsel_EXMEM  <= WBsel_IDEX;
        MemRW_EXMEM  <= MemRW_IDEX;
        regWen_EXMEM <= regWen_IDEX;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a behavioural model checked every rising edge, plus directed literal checks.
// Expectations follow EX_FWD_EN the same way the design does.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read_data_1_IDEX, read_data_2_IDEX, immgen_IDEX, pc_IDEX;
  logic [3:0]  Alu_sel_IDEX;
  logic        Asel_IDEX, Bsel_IDEX, BrUn_IDEX, MemRW_IDEX, regWen_IDEX;
  logic [1:0]  WBsel_IDEX;
  logic [4:0]  rd_IDEX, rs1_IDEX, rs2_IDEX, rd_MEMWB;
  logic [31:0] wb_data_MEMWB;
  logic        regWen_MEMWB, flush_EX;
  logic        BrEq, BrLt;
  logic [31:0] alu_EXMEM, store_data_EXMEM, pc_plus4_EXMEM;
  logic [4:0]  rd_EXMEM;
  logic [1:0]  WBsel_EXMEM;
  logic        MemRW_EXMEM, regWen_EXMEM;

  int checks = 0;
  int failures = 0;

  // Model state: what the EX/MEM register must hold.
  logic [31:0] m_alu, m_store, m_pc4;
  logic [4:0]  m_rd;
  logic [1:0]  m_wbsel;
  logic        m_memrw, m_regwen;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .read_data_1_IDEX(read_data_1_IDEX), .read_data_2_IDEX(read_data_2_IDEX),
    .immgen_IDEX(immgen_IDEX), .pc_IDEX(pc_IDEX),
    .Alu_sel_IDEX(Alu_sel_IDEX), .Asel_IDEX(Asel_IDEX), .Bsel_IDEX(Bsel_IDEX),
    .BrUn_IDEX(BrUn_IDEX), .MemRW_IDEX(MemRW_IDEX), .regWen_IDEX(regWen_IDEX),
    .WBsel_IDEX(WBsel_IDEX), .rd_IDEX(rd_IDEX), .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX),
    .wb_data_MEMWB(wb_data_MEMWB), .rd_MEMWB(rd_MEMWB), .regWen_MEMWB(regWen_MEMWB),
    .flush_EX(flush_EX), .BrEq(BrEq), .BrLt(BrLt),
    .alu_EXMEM(alu_EXMEM), .store_data_EXMEM(store_data_EXMEM), .pc_plus4_EXMEM(pc_plus4_EXMEM),
    .rd_EXMEM(rd_EXMEM), .WBsel_EXMEM(WBsel_EXMEM), .MemRW_EXMEM(MemRW_EXMEM),
    .regWen_EXMEM(regWen_EXMEM)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value an instruction reading register rs would see, given the model's pipeline contents.
  function automatic logic [31:0] modelOperand(input logic [4:0] rs, input logic [31:0] rf_val);
`ifdef EX_FWD_EN
    if (rs != 5'd0 && m_regwen && m_rd == rs && (m_wbsel == 2'b01 || m_wbsel == 2'b10))
      return (m_wbsel == 2'b10) ? m_pc4 : m_alu;
    if (rs != 5'd0 && regWen_MEMWB && rd_MEMWB == rs)
      return wb_data_MEMWB;
`endif
    return rf_val;
  endfunction

  // Signed less-than done by biasing both values into unsigned range.
  function automatic logic signedLess(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] modelAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh  = int'(b % 32);
    ext = {{32{a[31]}}, a};
    case (op)
      4'd0:  return 32'(64'(a) + 64'(b));
      4'd1:  return 32'(64'(a) + 64'(~b) + 64'd1);
      4'd2:  return 32'(64'(a) * (64'd1 << sh));
      4'd3:  return signedLess(a, b) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return 32'(64'(a) / (64'd1 << sh));
      4'd7:  return ext[31+sh -: 32];
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alu <= 0; m_store <= 0; m_pc4 <= 0; m_rd <= 0; m_wbsel <= 0; m_memrw <= 0; m_regwen <= 0;
    end else begin
      m_alu   <= modelAlu(Alu_sel_IDEX,
                          Asel_IDEX ? pc_IDEX : modelOperand(rs1_IDEX, read_data_1_IDEX),
                          Bsel_IDEX ? immgen_IDEX : modelOperand(rs2_IDEX, read_data_2_IDEX));
      m_store <= modelOperand(rs2_IDEX, read_data_2_IDEX);
      m_pc4   <= 32'(64'(pc_IDEX) + 64'd4);
      m_rd     <= flush_EX ? 5'd0 : rd_IDEX;
      m_wbsel  <= flush_EX ? 2'b01 : WBsel_IDEX;
      m_memrw  <= flush_EX ? 1'b0 : MemRW_IDEX;
      m_regwen <= flush_EX ? 1'b0 : regWen_IDEX;
    end
  end

  // Compare process, sampled mid-cycle away from the falling capture edge.
  always @(posedge clk) begin
    logic [31:0] fa, fb;
    fa = modelOperand(rs1_IDEX, read_data_1_IDEX);
    fb = modelOperand(rs2_IDEX, read_data_2_IDEX);
    checkOutput("cyc_alu", alu_EXMEM, m_alu);
    checkOutput("cyc_store", store_data_EXMEM, m_store);
    checkOutput("cyc_pc4", pc_plus4_EXMEM, m_pc4);
    checkOutput("cyc_rd", {27'd0, rd_EXMEM}, {27'd0, m_rd});
    checkOutput("cyc_wbsel", {30'd0, WBsel_EXMEM}, {30'd0, m_wbsel});
    checkOutput("cyc_memrw", {31'd0, MemRW_EXMEM}, {31'd0, m_memrw});
    checkOutput("cyc_regwen", {31'd0, regWen_EXMEM}, {31'd0, m_regwen});
    checkOutput("cyc_breq", {31'd0, BrEq}, {31'd0, fa == fb});
    checkOutput("cyc_brlt", {31'd0, BrLt}, {31'd0, BrUn_IDEX ? (fa < fb) : signedLess(fa, fb)});
  end

  task automatic clearInputs();
    read_data_1_IDEX = 0; read_data_2_IDEX = 0; immgen_IDEX = 0; pc_IDEX = 0;
    Alu_sel_IDEX = 0; Asel_IDEX = 0; Bsel_IDEX = 0; BrUn_IDEX = 0; MemRW_IDEX = 0;
    regWen_IDEX = 0; WBsel_IDEX = 2'b01; rd_IDEX = 0; rs1_IDEX = 0; rs2_IDEX = 0;
    wb_data_MEMWB = 0; rd_MEMWB = 0; regWen_MEMWB = 0; flush_EX = 0;
  endtask

  // Drives one ALU op with no forwarding sources and waits past the capture edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    clearInputs();
    Alu_sel_IDEX = op; read_data_1_IDEX = a; read_data_2_IDEX = b;
    @(negedge clk); #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_alu"}, alu_EXMEM, 32'd0);
    checkOutput({tag, "_store"}, store_data_EXMEM, 32'd0);
    checkOutput({tag, "_pc4"}, pc_plus4_EXMEM, 32'd0);
    checkOutput({tag, "_rd"}, {27'd0, rd_EXMEM}, 32'd0);
    checkOutput({tag, "_wbsel"}, {30'd0, WBsel_EXMEM}, 32'd0);
    checkOutput({tag, "_memrw"}, {31'd0, MemRW_EXMEM}, 32'd0);
    checkOutput({tag, "_regwen"}, {31'd0, regWen_EXMEM}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    #2;
    checkAllZero("reset");

    // ADD 5+7 into x3, issued while reset releases.
    #5;
    rst_n = 1'b1;
    read_data_1_IDEX = 5; read_data_2_IDEX = 7; rd_IDEX = 3; regWen_IDEX = 1;
    @(negedge clk); #1;
    checkOutput("add_alu", alu_EXMEM, 32'd12);
    checkOutput("add_rd", {27'd0, rd_EXMEM}, 32'd3);
    checkOutput("add_regwen", {31'd0, regWen_EXMEM}, 32'd1);
    checkOutput("add_store", store_data_EXMEM, 32'd7);
    checkOutput("add_pc4", pc_plus4_EXMEM, 32'd4);

    // SUB x3 - 2 with both EX/MEM and MEM/WB claiming x3.
    clearInputs();
    Alu_sel_IDEX = 1; rs1_IDEX = 3; read_data_1_IDEX = 0; rs2_IDEX = 4; read_data_2_IDEX = 2;
    rd_MEMWB = 3; wb_data_MEMWB = 99; regWen_MEMWB = 1; rd_IDEX = 6; regWen_IDEX = 1;
    @(negedge clk); #1;
`ifdef EX_FWD_EN
    checkOutput("fwd_priority", alu_EXMEM, 32'd10);
`else
    checkOutput("nofwd_sub", alu_EXMEM, 32'hFFFF_FFFE);
`endif

    // MEM/WB-only forward; rd=0 with regWen=1 captured as-is.
    clearInputs();
    rs1_IDEX = 8; read_data_1_IDEX = 0; read_data_2_IDEX = 2;
    rd_MEMWB = 8; wb_data_MEMWB = 99; regWen_MEMWB = 1; rd_IDEX = 0; regWen_IDEX = 1;
    @(negedge clk); #1;
`ifdef EX_FWD_EN
    checkOutput("fwd_memwb", alu_EXMEM, 32'd101);
`else
    checkOutput("nofwd_memwb", alu_EXMEM, 32'd2);
`endif
    checkOutput("rd0_regwen", {31'd0, regWen_EXMEM}, 32'd1);

    // Signed vs unsigned compare; rs=0 must not pick up the rd=0 entry in EX/MEM.
    clearInputs();
    read_data_1_IDEX = 32'hFFFF_FFFF; read_data_2_IDEX = 1;
    #1;
    checkOutput("brlt_signed", {31'd0, BrLt}, 32'd1);
    checkOutput("breq_signed", {31'd0, BrEq}, 32'd0);
    BrUn_IDEX = 1;
    #1;
    checkOutput("brlt_unsigned", {31'd0, BrLt}, 32'd0);
    checkOutput("breq_unsigned", {31'd0, BrEq}, 32'd0);

    applyStimulus(4'd3, 32'hFFFF_FFFF, 32'd1);
    checkOutput("slt", alu_EXMEM, 32'd1);
    applyStimulus(4'd4, 32'hFFFF_FFFF, 32'd1);
    checkOutput("sltu", alu_EXMEM, 32'd0);
    applyStimulus(4'd0, 32'hFFFF_FFFF, 32'd2);
    checkOutput("add_wrap", alu_EXMEM, 32'd1);
    applyStimulus(4'd2, 32'd1, 32'h0000_0024);
    checkOutput("sll_b40", alu_EXMEM, 32'd16);
    applyStimulus(4'd7, 32'h8000_0000, 32'd4);
    checkOutput("sra", alu_EXMEM, 32'hF800_0000);
    applyStimulus(4'd6, 32'h8000_0000, 32'd4);
    checkOutput("srl", alu_EXMEM, 32'h0800_0000);
    applyStimulus(4'd5, 32'h0000_F0F0, 32'h0000_FF00);
    checkOutput("xor", alu_EXMEM, 32'h0000_0FF0);
    applyStimulus(4'd8, 32'h0000_F0F0, 32'h0000_FF00);
    checkOutput("or", alu_EXMEM, 32'h0000_FFF0);
    applyStimulus(4'd9, 32'h0000_F0F0, 32'h0000_FF00);
    checkOutput("and", alu_EXMEM, 32'h0000_F000);
    applyStimulus(4'd12, 32'd5, 32'd6);
    checkOutput("op12_zero", alu_EXMEM, 32'd0);

    // pc/imm operands: result uses them, branch compare still sees the registers.
    clearInputs();
    Asel_IDEX = 1; Bsel_IDEX = 1; pc_IDEX = 32'h100; immgen_IDEX = 8;
    read_data_1_IDEX = 5; read_data_2_IDEX = 5;
    #1;
    checkOutput("breq_asel", {31'd0, BrEq}, 32'd1);
    @(negedge clk); #1;
    checkOutput("asel_add", alu_EXMEM, 32'h108);
    checkOutput("pc4", pc_plus4_EXMEM, 32'h104);

    clearInputs();
    Alu_sel_IDEX = 10; Bsel_IDEX = 1; immgen_IDEX = 32'd1234; pc_IDEX = 32'hFFFF_FFFC;
    @(negedge clk); #1;
    checkOutput("passb", alu_EXMEM, 32'd1234);
    checkOutput("pc4_wrap", pc_plus4_EXMEM, 32'd0);

    // Flush turns a store with writeback into a bubble but keeps the data.
    clearInputs();
    read_data_1_IDEX = 1; read_data_2_IDEX = 1; MemRW_IDEX = 1; regWen_IDEX = 1;
    rd_IDEX = 9; WBsel_IDEX = 2'b00; flush_EX = 1;
    @(negedge clk); #1;
    checkOutput("flush_memrw", {31'd0, MemRW_EXMEM}, 32'd0);
    checkOutput("flush_regwen", {31'd0, regWen_EXMEM}, 32'd0);
    checkOutput("flush_rd", {27'd0, rd_EXMEM}, 32'd0);
    checkOutput("flush_wbsel", {30'd0, WBsel_EXMEM}, 32'd1);
    checkOutput("flush_alu", alu_EXMEM, 32'd2);

    // Reset asserted between edges must clear everything at once.
    clearInputs();
    read_data_1_IDEX = 3; read_data_2_IDEX = 4; rd_IDEX = 5; regWen_IDEX = 1; MemRW_IDEX = 1;
    pc_IDEX = 32'h40;
    @(negedge clk); #1;
    checkOutput("pre_reset_alu", alu_EXMEM, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    clearInputs();
    read_data_1_IDEX = 2; read_data_2_IDEX = 2; rd_IDEX = 4; regWen_IDEX = 1;
    @(negedge clk); #1;
    checkOutput("post_reset_alu", alu_EXMEM, 32'd4);
    checkOutput("post_reset_rd", {27'd0, rd_EXMEM}, 32'd4);

    clearInputs();
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-002 clk  in  1  stage clock; all registers update on the falling edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 read_data_1_IDEX, read_data_2_IDEX, immgen_IDEX, pc_IDEX  in  32 each  operands from ID/EX.
REQ-005 Alu_sel_IDEX  in  4  ALU op; Asel_IDEX, Bsel_IDEX, BrUn_IDEX, MemRW_IDEX, regWen_IDEX  in  1 each.
REQ-006 WBsel_IDEX  in  2  writeback select (00 mem, 01 ALU, 10 PC+4, 11 reserved); rd_IDEX  in  5  destination register.
REQ-007 rs1_IDEX, rs2_IDEX  in  5 each; wb_data_MEMWB  in  32; rd_MEMWB  in  5; regWen_MEMWB  in  1  (forwarding sources).
REQ-008 flush_EX  in  1  converts the instruction being captured into a bubble.
REQ-009 BrEq, BrLt  out  1 each  combinational branch-compare results to control.
REQ-010 alu_EXMEM, store_data_EXMEM, pc_plus4_EXMEM  out  32 each  registered.
REQ-011 rd_EXMEM  out  5; WBsel_EXMEM  out  2; MemRW_EXMEM, regWen_EXMEM  out  1  registered.

Function
REQ-012 Operand A = Asel ? pc_IDEX : fwdA; operand B = Bsel ? immgen_IDEX : fwdB; fwdA/fwdB = forwarded rs1/rs2 values (REQ-026), else read_data_1/2_IDEX.
REQ-013 Alu_sel: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass-B; 11-15 yield 0.
REQ-014 ADD/SUB wrap modulo 2^32; shifts use B[4:0] only; SLT/SLTU yield 32'h1 or 32'h0.
REQ-015 BrEq = (fwdA == fwdB); BrLt = fwdA < fwdB, signed when BrUn=0, unsigned when BrUn=1; independent of Asel/Bsel.
REQ-016 Latency one falling edge: ALU result, fwdB (store data), pc_IDEX+4, and controls captured into *_EXMEM.
REQ-017 pc_plus4 wraps 32'hFFFFFFFC -> 32'h0.
REQ-018 flush_EX=1 at capture: regWen_EXMEM=0, MemRW_EXMEM=0, rd_EXMEM=0, WBsel_EXMEM=01; data fields still captured.
REQ-019 rd_IDEX=0 with regWen_IDEX=1 is captured as-is; never a forwarding source.
REQ-020 No stall input; stage captures every falling edge.

Reset
REQ-021 rst_n low asynchronously clears every registered output to 0, including mid-operation; BrEq/BrLt remain combinational.
REQ-022 First falling edge after rst_n rises captures normally.
REQ-023 Reset state is a bubble: writes no register, no memory write.

Configuration
REQ-024 Macro EX_FWD_EN compiles operand forwarding in; forwarding ports exist in both builds.
REQ-025 Without EX_FWD_EN: fwdA = read_data_1_IDEX, fwdB = read_data_2_IDEX; forwarding inputs ignored.
REQ-026 With EX_FWD_EN, per operand rsX: if regWen_EXMEM, rd_EXMEM!=0, rd_EXMEM==rsX, WBsel_EXMEM in {01,10} -> (WBsel_EXMEM==10 ? pc_plus4_EXMEM : alu_EXMEM); else if regWen_MEMWB, rd_MEMWB!=0, rd_MEMWB==rsX -> wb_data_MEMWB; else register-file value.
REQ-027 EX/MEM source has priority over MEM/WB; EX/MEM load (WBsel 00) not forwarded (load-use stall upstream).

Verification
REQ-028 rd1=5, rd2=7, Asel=0, Bsel=0, Alu_sel=0, rd=3, regWen=1 -> after one falling edge alu_EXMEM=12, rd_EXMEM=3, regWen_EXMEM=1.
REQ-029 rd1=32'hFFFFFFFF, rd2=1: BrUn=0 -> BrLt=1; BrUn=1 -> BrLt=0; BrEq=0 both.
REQ-030 EX_FWD_EN: ADD x3=12 then SUB rs1=3, read_data_1=0, rd2=2 -> alu_EXMEM=10; same with rd_MEMWB=3, wb_data=99 still yields 10 (priority).
REQ-031 flush_EX=1 with MemRW=1, regWen=1, rd=9 -> MemRW_EXMEM=0, regWen_EXMEM=0, rd_EXMEM=0.
REQ-032 Assert rst_n=0 between edges with outputs non-zero -> all registered outputs 0 immediately, before next edge.
REQ-033 Without EX_FWD_EN, REQ-030 stimulus -> alu_EXMEM=32'hFFFFFFFE (0-2).
